bombe_sweep_ctrl: RTL and testbench
===================================

// Module: bombe_sweep_ctrl
// PURPOSE
//  Sequencer that drives the enigma datapath through an exhaustive rotor-position sweep for one crib pair.
//  It performs a (plain, cipher) sweep: for each start position 0..NUM_POS-1 it does the following.
//   - Loads the rotor.
//   - Strobes the plain char.
//   - Waits for the datapath to settle.
//   - Compares the result to the cipher char.
//  Sits between the board controls (go/abort) and the enigma/rotor datapath inside the bombe.
//  Reports whether any position matched, the first matching position, and the match count.
// PARAMETERS
//  NUM_POS        26  number of rotor start positions swept (0..NUM_POS-1)
//  SETTLE_CYCLES  4   cycles waited after char strobe before sampling enigma output (>=1)
//  CHAR_W         8   width of character codes
//  POS_W          5   width of rotor position / match count
// PORTS
//  clk          in   1       system clock (CLOCK_50 at top level)
//  resetn       in   1       asynchronous, active-low reset
//  go           in   1       start request, level; a sweep starts on its rising edge
//  abort        in   1       synchronous abort, active-high
//  crib_plain   in   CHAR_W  plaintext char of crib, latched at start
//  crib_cipher  in   CHAR_W  expected ciphertext char, latched at start
//  enigma_char  in   CHAR_W  enigma datapath output letter
//  rotor_load   out  1       one-cycle pulse: load rotor_pos into rotor
//  rotor_pos    out  POS_W   rotor start position under test
//  char_strobe  out  1       one-cycle pulse: present char_out to enigma
//  char_out     out  CHAR_W  char presented to enigma (= latched crib_plain)
//  busy         out  1       high in every state except IDLE and DONE
//  done         out  1       high while in DONE
//  found        out  1       valid in DONE: at least one position matched
//  first_pos    out  POS_W   lowest matching position (0 if none)
//  match_count  out  POS_W   number of matching positions
//  state_out    out  5       current state encoding (for LEDR debug)
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, go_q=0; all outputs are 0.
//  Start edge = go & ~go_q, with go_q registered each clk.
//  State encoding: IDLE=0 LOAD=1 APPLY=2 SETTLE=3 COMPARE=4 NEXT=5 DONE=6.
//  IDLE
//   - On start edge: latch crib_plain/crib_cipher; pos=0, match_count=0, first_pos=0, found=0.
//   - If crib_plain==crib_cipher (enigma never self-maps): go straight to DONE, found=0.
//   - Otherwise go to LOAD.
//  LOAD: rotor_load=1, rotor_pos=pos -> APPLY.
//  APPLY: char_strobe=1, char_out=plain latch; clear settle counter -> SETTLE.
//  SETTLE: stay SETTLE_CYCLES cycles total, then -> COMPARE.
//  COMPARE
//   - If enigma_char==cipher latch: increment match_count.
//   - If match_count was 0 before the increment: first_pos=pos.
//   - -> NEXT.
//  NEXT
//   - If pos==NUM_POS-1: -> DONE, found=(match_count!=0).
//   - Otherwise pos=pos+1 (never wraps) -> LOAD.
//  DONE
//   - done=1; results are held.
//   - A start edge begins a new sweep exactly as from IDLE.
//   - go held high does not restart.
//  Timing
//   - Each position costs SETTLE_CYCLES+4 cycles.
//   - A start edge at edge k puts LOAD at k+1. done rises at edge k+NUM_POS*(SETTLE_CYCLES+4)+1, i.e. k+209 with defaults.
//  abort=1 in any state -> IDLE next edge; clears busy/done/found/first_pos/match_count; no pulses are issued that cycle. abort beats go.
//  rotor_pos/char_out hold their last value between pulses; rotor_load/char_strobe are never high together.
//  Results (found/first_pos/match_count) are meaningful only when done=1.
//  resetn asserted mid-sweep returns to IDLE immediately; no partial results are retained.
// TESTING
//  Single match. Bench model: enigma_char=(plain+pos)%26. Set plain=3, cipher=10, pulse go.
//   -> found=1, first_pos=7, match_count=1; done at +209 cycles; exactly 26 rotor_load pulses.
//  No match. Model returns 25 always; plain=3, cipher=10.
//   -> done=1, found=0, first_pos=0, match_count=0.
//  Self-map. plain=cipher=4.
//   -> DONE one cycle after the start edge, found=0, zero rotor_load pulses.
//  Multiple matches. Model returns cipher for pos in {2,25}.
//   -> first_pos=2, match_count=2; the pos=25 boundary compare is counted.
//  Abort mid-sweep. abort=1 at pos=12 SETTLE.
//   -> IDLE next cycle, busy=0, done=0, no further pulses; a later go edge restarts at pos 0.
//  Reset and level go. Hold go high through DONE -> no restart.
//   -> Drop resetn mid-LOAD: outputs 0 asynchronously; state_out=0.

Source files
------------

// File: rtl/bombe_sweep_ctrl_if.sv
// Link between the sweep sequencer and the enigma/rotor datapath.
// The master drives the rotor and char pulses. The slave returns the enigma output letter.
interface bombe_sweep_ctrl_if #(
  parameter int unsigned CHAR_W = 8,
  parameter int unsigned POS_W  = 5
);
  logic              rotor_load;
  logic [POS_W-1:0]  rotor_pos;
  logic              char_strobe;
  logic [CHAR_W-1:0] char_out;
  logic [CHAR_W-1:0] enigma_char;

  modport master (
    output rotor_load,
    output rotor_pos,
    output char_strobe,
    output char_out,
    input  enigma_char
  );

  modport slave (
    input  rotor_load,
    input  rotor_pos,
    input  char_strobe,
    input  char_out,
    output enigma_char
  );
endinterface

// File: rtl/bombe_sweep_ctrl.sv
// Bombe sweep sequencer: steps the rotor through every start position for one crib pair
// and records whether any position matched, the first match, and the number of matches.
module bombe_sweep_ctrl #(
  parameter int unsigned NUM_POS       = 26,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CHAR_W        = 8,
  parameter int unsigned POS_W         = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic              abort,
  input  logic [CHAR_W-1:0] crib_plain,
  input  logic [CHAR_W-1:0] crib_cipher,
  bombe_sweep_ctrl_if.master dp,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [POS_W-1:0]  first_pos,
  output logic [POS_W-1:0]  match_count,
  output logic [4:0]        state_out
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [POS_W-1:0] PosLast    = POS_W'(NUM_POS - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StApply   = 3'd2,
    StSettle  = 3'd3,
    StCompare = 3'd4,
    StNext    = 3'd5,
    StDone    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic              go_q;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CHAR_W-1:0] plain_q, plain_d;
  logic [CHAR_W-1:0] cipher_q, cipher_d;
  logic [POS_W-1:0]  count_q, count_d;
  logic [POS_W-1:0]  first_q, first_d;
  logic              found_q, found_d;
  logic              start;

  assign start = go & ~go_q;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    plain_d  = plain_q;
    cipher_d = cipher_q;
    count_d  = count_q;
    first_d  = first_q;
    found_d  = found_q;
    dp.rotor_load  = 1'b0;
    dp.char_strobe = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          plain_d  = crib_plain;
          cipher_d = crib_cipher;
          pos_d    = '0;
          count_d  = '0;
          first_d  = '0;
          found_d  = 1'b0;
          // An enigma never maps a letter to itself, so no position can match.
          state_d  = (crib_plain == crib_cipher) ? StDone : StLoad;
        end
      end
      StLoad: begin
        dp.rotor_load = 1'b1;
        state_d       = StApply;
      end
      StApply: begin
        dp.char_strobe = 1'b1;
        cnt_d          = '0;
        state_d        = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) state_d = StCompare;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      StCompare: begin
        if (dp.enigma_char == cipher_q) begin
          count_d = count_q + 1'b1;
          if (count_q == '0) first_d = pos_q;
        end
        state_d = StNext;
      end
      StNext: begin
        if (pos_q == PosLast) begin
          found_d = (count_q != '0);
          state_d = StDone;
        end else begin
          pos_d   = pos_q + 1'b1;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a simultaneous start edge.
    if (abort) begin
      state_d        = StIdle;
      count_d        = '0;
      first_d        = '0;
      found_d        = 1'b0;
      dp.rotor_load  = 1'b0;
      dp.char_strobe = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      go_q     <= 1'b0;
      pos_q    <= '0;
      cnt_q    <= '0;
      plain_q  <= '0;
      cipher_q <= '0;
      count_q  <= '0;
      first_q  <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      go_q     <= go;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      plain_q  <= plain_d;
      cipher_q <= cipher_d;
      count_q  <= count_d;
      first_q  <= first_d;
      found_q  <= found_d;
    end
  end

  assign dp.rotor_pos = pos_q;
  assign dp.char_out  = plain_q;
  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign done         = (state_q == StDone);
  assign found        = found_q;
  assign first_pos    = first_q;
  assign match_count  = count_q;
  assign state_out    = {2'b00, state_q};

endmodule

// File: tb/tb_bombe_sweep_ctrl.sv
// Scoreboard bench for bombe_sweep_ctrl with a behavioural enigma datapath model.
module tb_bombe_sweep_ctrl;
  localparam int unsigned NumPos = 26;
  localparam int unsigned Settle = 4;
  localparam int unsigned CharW  = 8;
  localparam int unsigned PosW   = 5;

  typedef struct {
    int unsigned found;
    int unsigned first;
    int unsigned count;
    int unsigned latency;
    int unsigned loads;
  } exp_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             go = 1'b0;
  logic             abort = 1'b0;
  logic [CharW-1:0] crib_plain = '0;
  logic [CharW-1:0] crib_cipher = '0;
  logic             busy, done, found;
  logic [PosW-1:0]  first_pos, match_count;
  logic [4:0]       state_out;

  bombe_sweep_ctrl_if #(.CHAR_W(CharW), .POS_W(PosW)) dp_if ();

  bombe_sweep_ctrl #(
    .NUM_POS(NumPos), .SETTLE_CYCLES(Settle), .CHAR_W(CharW), .POS_W(PosW)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go), .abort(abort),
    .crib_plain(crib_plain), .crib_cipher(crib_cipher), .dp(dp_if),
    .busy(busy), .done(done), .found(found), .first_pos(first_pos),
    .match_count(match_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int mode = 0;
  int n_checks = 0;
  int n_errors = 0;
  int load_cnt = 0;
  int strobe_cnt = 0;
  int overlap_cnt = 0;
  int l0 = 0;
  int s0 = 0;
  exp_t sb[$];
  logic [PosW-1:0]  seen_rot;
  logic [CharW-1:0] seen_char;

  // 0: (plain+rot)%26, 1: always 25, 2: cipher at rot 2 and 25 only
  function automatic int model_char(int m, int ch, int rot, int c);
    if (m == 0) return (ch + rot) % 26;
    if (m == 1) return 25;
    return (rot == 2 || rot == 25) ? c : 25;
  endfunction

  function automatic exp_t model_sweep(int m, int p, int c);
    exp_t e;
    e.found = 0; e.first = 0; e.count = 0;
    if (p == c) begin
      e.latency = 1;
      e.loads   = 0;
      return e;
    end
    for (int pos = 0; pos < int'(NumPos); pos++) begin
      if (model_char(m, p, pos, c) == c) begin
        if (e.count == 0) e.first = pos;
        e.count++;
      end
    end
    e.found   = (e.count != 0) ? 1 : 0;
    e.latency = NumPos * (Settle + 4) + 1;
    e.loads   = NumPos;
    return e;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seen_rot  <= '0;
      seen_char <= '0;
    end else begin
      if (dp_if.rotor_load)  seen_rot  <= dp_if.rotor_pos;
      if (dp_if.char_strobe) seen_char <= dp_if.char_out;
    end
  end

  always @(posedge clk) begin
    if (dp_if.rotor_load)  load_cnt   <= load_cnt + 1;
    if (dp_if.char_strobe) strobe_cnt <= strobe_cnt + 1;
    if (dp_if.rotor_load && dp_if.char_strobe) overlap_cnt <= overlap_cnt + 1;
  end

  always_comb
    dp_if.enigma_char = CharW'(model_char(mode, int'(seen_char), int'(seen_rot), int'(crib_cipher)));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_sweep(input int m, input int p, input int c, input bit push);
    mode        = m;
    crib_plain  = CharW'(p);
    crib_cipher = CharW'(c);
    if (push) sb.push_back(model_sweep(m, p, c));
    l0 = load_cnt;
    s0 = strobe_cnt;
    go = 1'b1;
  endtask

  task automatic finish_sweep(input string tag, input int cyc0);
    int cyc;
    exp_t e;
    cyc = cyc0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 2000);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(cyc), e.latency);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_found"}, 32'(found), e.found);
    check({tag, "_first_pos"}, 32'(first_pos), e.first);
    check({tag, "_match_count"}, 32'(match_count), e.count);
    check({tag, "_loads"}, 32'(load_cnt - l0), e.loads);
    check({tag, "_strobes"}, 32'(strobe_cnt - s0), e.loads);
  endtask

  initial begin
    int cyc;
    int la;
    int sa;
    // Reset state
    tick();
    check("rst_state", 32'(state_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_load", 32'(dp_if.rotor_load), 0);
    check("rst_strobe", 32'(dp_if.char_strobe), 0);
    resetn = 1'b1;
    tick();
    check("idle_state", 32'(state_out), 0);

    // Single match, then hold go high through DONE
    start_sweep(0, 3, 10, 1'b1);
    finish_sweep("single", 0);
    for (int i = 0; i < 20; i++) tick();
    check("level_go_state", 32'(state_out), 6);
    check("level_go_loads", 32'(load_cnt - l0), NumPos);
    go = 1'b0;
    tick();

    start_sweep(1, 3, 10, 1'b1);
    finish_sweep("nomatch", 0);
    go = 1'b0;
    tick();

    start_sweep(0, 4, 4, 1'b1);
    finish_sweep("selfmap", 0);
    go = 1'b0;
    tick();

    start_sweep(2, 3, 10, 1'b1);
    finish_sweep("multi", 0);
    go = 1'b0;
    tick();

    // Abort at pos 12 SETTLE
    start_sweep(0, 3, 10, 1'b0);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(state_out == 5'd3 && dp_if.rotor_pos == 5'd12) && cyc < 500);
    check("abort_reach", 32'(cyc < 500), 1);
    abort = 1'b1;
    go    = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_state", 32'(state_out), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_count", 32'(match_count), 0);
    la = load_cnt;
    sa = strobe_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_loads", 32'(load_cnt - la), 0);
    check("abort_no_strobes", 32'(strobe_cnt - sa), 0);
    start_sweep(0, 3, 10, 1'b1);
    tick();
    check("restart_state", 32'(state_out), 1);
    check("restart_pos", 32'(dp_if.rotor_pos), 0);
    check("restart_load", 32'(dp_if.rotor_load), 1);
    finish_sweep("restart", 1);
    go = 1'b0;
    tick();

    // Asynchronous reset during LOAD
    start_sweep(0, 3, 10, 1'b0);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(state_out == 5'd1 && dp_if.rotor_pos == 5'd3) && cyc < 200);
    check("rstload_reach", 32'(cyc < 200), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("rstload_state", 32'(state_out), 0);
    check("rstload_load", 32'(dp_if.rotor_load), 0);
    check("rstload_busy", 32'(busy), 0);
    check("rstload_pos", 32'(dp_if.rotor_pos), 0);
    check("rstload_char", 32'(dp_if.char_out), 0);
    go = 1'b0;
    #1;
    resetn = 1'b1;
    tick();
    check("rstload_idle", 32'(state_out), 0);

    check("no_overlap", 32'(overlap_cnt), 0);
    check("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
